// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM handshake and
// applies delayed-branch redirects from ID. Optional feature macro: IF_ADEL_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned STALL_W  = 6,
  parameter int unsigned BR_W     = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic [BR_W-1:0]    br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic [31:0]        if_inst,
  output logic               stallreq,
  output logic               inst_sram_req,
  output logic [31:0]        inst_sram_addr,
  input  logic               inst_sram_addr_ok,
  input  logic               inst_sram_data_ok,
  input  logic [31:0]        inst_sram_rdata
`ifdef IF_ADEL_EN
  ,
  output logic               if_adel
`endif
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e        state_q;
  logic [AW-1:0] fetch_addr_q;
  logic [AW-1:0] next_pc_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   inst_buf_q;
  logic [31:0]   inst_q;
  logic          ce_q;
  logic          req_q;
  logic          stallreq_q;
  logic          br_pend_q;
  logic [AW-1:0] br_target_q;

  logic          br_e;
  logic [AW-1:0] br_addr;
  logic          consume;
  logic          launch;
  logic [AW-1:0] seq_pc_d;
  logic [AW-1:0] launch_pc;
  logic [AW-1:0] fetch_pc;
  logic          skip_req;

  assign br_e    = br_bus[BR_W-1];
  assign br_addr = br_bus[AW-1:0];

  // A branch seen in the consuming cycle belongs to the delay slot being handed over.
  always_comb begin
    consume = (state_q == S_HOLD) && !stall[1];
    if (consume && br_e) begin
      seq_pc_d = br_addr;
    end else if (br_pend_q) begin
      seq_pc_d = br_target_q;
    end else begin
      seq_pc_d = fetch_addr_q + 32'd4;
    end
    launch    = !stall[0] && ((state_q == S_IDLE) || consume);
    launch_pc = (state_q == S_IDLE) ? next_pc_q : seq_pc_d;
  end

`ifdef IF_ADEL_EN
  logic unused_bits;
  logic adel_buf_q;
  logic adel_q;

  assign unused_bits = ^stall[STALL_W-1:2];
  assign skip_req    = (launch_pc[1:0] != 2'b00);
  assign fetch_pc    = launch_pc;
  assign if_adel     = adel_q;

  // Misaligned fetches bypass the SRAM and deliver a flagged nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adel_buf_q <= 1'b0;
      adel_q     <= 1'b0;
    end else begin
      adel_q <= consume ? adel_buf_q : 1'b0;
      if (launch) begin
        adel_buf_q <= skip_req;
      end
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{stall[STALL_W-1:2], launch_pc[1:0]};
  assign skip_req    = 1'b0;
  assign fetch_pc    = {launch_pc[AW-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      next_pc_q    <= RESET_PC;
      pc_q         <= RESET_PC - 32'd4;
      inst_buf_q   <= '0;
      inst_q       <= '0;
      ce_q         <= 1'b0;
      req_q        <= 1'b0;
      stallreq_q   <= 1'b0;
      br_pend_q    <= 1'b0;
      br_target_q  <= '0;
    end else begin
      ce_q   <= 1'b0;
      inst_q <= '0;

      if (br_e && !consume) begin
        br_pend_q   <= 1'b1;
        br_target_q <= br_addr;
      end else if (consume) begin
        br_pend_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
        end
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            inst_buf_q <= inst_sram_rdata;
            state_q    <= S_HOLD;
            stallreq_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (consume) begin
            ce_q      <= 1'b1;
            pc_q      <= fetch_addr_q;
            inst_q    <= inst_buf_q;
            next_pc_q <= seq_pc_d;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Start the next fetch; overrides the IDLE fall-back chosen above.
      if (launch) begin
        fetch_addr_q <= fetch_pc;
        if (skip_req) begin
          state_q    <= S_HOLD;
          inst_buf_q <= '0;
        end else begin
          state_q    <= S_REQ;
          req_q      <= 1'b1;
          stallreq_q <= 1'b1;
        end
      end
    end
  end

  assign if_to_id_bus   = {ce_q, pc_q};
  assign if_inst        = inst_q;
  assign stallreq       = stallreq_q;
  assign inst_sram_req  = req_q;
  assign inst_sram_addr = {fetch_addr_q[AW-1:2], 2'b00};

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the ID stage's `if_to_id_bus`/instruction input and the consumer of its `br_bus`.
- Owns the PC register and drives the instruction SRAM through a req/addr_ok/data_ok handshake.
- Applies branch/jump redirects from ID, honouring the MIPS delay slot.
- Holds a fetched instruction while the pipeline is stalled and raises `stallreq` while a fetch is outstanding.

Parameters:
- RESET_PC, 32'hBFC0_0000: address of the first fetch after reset.
- STALL_W, 6: width of the stall bus. Bit 0 is the PC stage; bit 1 is the IF/ID register.
- BR_W, 33: width of `br_bus`, laid out as {br_e, br_addr[31:0]}.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous reset, active-low.
- stall  in  STALL_W  pipeline stall vector from ctrl; `stall[0]`=1 freezes the PC.
- br_bus  in  BR_W  {br_e, br_addr} from ID, valid in the same cycle.
- if_to_id_bus  out  33  {ce, pc[31:0]}; `ce`=1 means the delivered instruction is valid.
- if_inst  out  32  instruction paired with `if_to_id_bus`.
- stallreq  out  1  requests a stall while a fetch is in flight.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address (word-aligned).
- inst_sram_addr_ok  in  1  request accepted.
- inst_sram_data_ok  in  1  read data valid.
- inst_sram_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, `rst_n`=0), all values take effect immediately:
  - state=IDLE.
  - pc=RESET_PC-4.
  - next_pc=RESET_PC.
  - br_pend=0.
  - All outputs 0 (`ce`=0, `if_inst`=0, `stallreq`=0, `inst_sram_req`=0).
  - An outstanding SRAM response arriving after reset is ignored.
- State machine:
  - IDLE: if `stall[0]`=0, go to REQ with fetch address = next_pc.
  - REQ: `inst_sram_req`=1, `inst_sram_addr`=fetch address, held stable until `addr_ok`.
    - `addr_ok`=1 → WAIT.
    - `addr_ok`=1 and `data_ok`=1 in the same cycle → WAIT, with data accepted in the next cycle only.
  - WAIT: `inst_sram_req`=0. On `data_ok`, capture `rdata` into inst_buf and go to HOLD.
  - HOLD: inst_buf valid.
    - When `stall[1]`=0, ID consumes it that cycle: `ce`=1, pc=fetch address.
    - Then compute next_pc and go to REQ in the same cycle if `stall[0]`=0, else IDLE.
- Output timing:
  - `stallreq`=1 in REQ and WAIT.
  - `stallreq`=0 in IDLE and HOLD.
  - `if_to_id_bus.ce`=1 only in the HOLD cycle where `stall[1]`=0; otherwise `ce`=0, pc holds its last value, and `if_inst`=0.
- next_pc selection, in priority order:
  1. br_pend=1 → br_target, then clear br_pend.
  2. Otherwise, fetch address+4 (modulo 2^32; 32'hFFFF_FFFC+4 = 0).
- Branch capture:
  - `br_e`=1 in any cycle sets br_pend=1 and br_target=`br_addr`.
  - A second `br_e` while br_pend=1 overwrites the target (last one wins).
- Delay slot:
  - The instruction at branch_pc+4 is always fetched and delivered.
  - The redirect affects only the fetch after the delay slot.
  - When `br_e` and HOLD consumption coincide, the consumed instruction is the delay slot. next_pc = `br_addr` directly, and br_pend is not set.
- Stall semantics:
  - `stall[0]`=1 blocks leaving IDLE/HOLD only.
  - REQ and WAIT are never abandoned.
  - `stall[1]`=1 keeps HOLD and inst_buf unchanged.
- `inst_sram_addr[1:0]` is always 2'b00.

Optional Feature:
- Macro: IF_ADEL_EN.
- When defined:
  - Adds output port `if_adel` (1 bit).
  - If the fetch address has [1:0]≠0, no SRAM request is issued: REQ is skipped, HOLD is entered directly with inst_buf=32'h0 (nop) and `if_adel`=1 alongside `ce`=1.
  - `if_adel` resets to 0.
- When undefined:
  - No `if_adel` port.
  - Address bits [1:0] are forced to 0 and fetch proceeds normally.

Test Plan:
- Reset then release; SRAM gives `addr_ok` and `data_ok` each one cycle after request → first `ce`=1 with pc=32'hBFC0_0000. Next fetch at 32'hBFC0_0004. `stallreq`=1 for exactly the REQ+WAIT cycles.
- Branch at 32'hBFC0_0010 with `br_e`=1, `br_addr`=32'hBFC0_0100 → delivered pcs are …0010, …0014 (delay slot), then …0100.
- `br_e` pulses while the delay-slot fetch is in WAIT → br_pend latched. The fetch after the delay slot goes to `br_addr`. No instruction from branch_pc+8 is delivered.
- `stall[1]`=1 for 5 cycles while in HOLD with inst 32'h3C01_1234 → `ce`=0 and no new `inst_sram_req` during the stall. On release, `ce`=1 with 32'h3C01_1234 exactly once.
- `rst_n` asserted while in WAIT, and `data_ok` arrives one cycle after release → response ignored. The first delivered pc is 32'hBFC0_0000 with the correct data from the new request.
- With IF_ADEL_EN, redirect to 32'hBFC0_0102 → no `inst_sram_req`. `ce`=1, `if_adel`=1, `if_inst`=0, pc=32'hBFC0_0102.
